// File: rtl/pwm_multicanal.sv
// pwm_multicanal: multi-channel PWM generator with push-button editing of per-channel frequency and duty
module pwm_multicanal #(
  parameter int N_CH     = 2,
  parameter int FREQ_W   = 4,
  parameter int DUTY_W   = 4,
  parameter int BASE_DIV = 2,
  parameter int FREQ_RST = 0,
  parameter int DUTY_RST = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int VW   = (FREQ_W > DUTY_W) ? FREQ_W : DUTY_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            opcion,
  input  logic            userOpcUp,
  input  logic            userOpcDown,
  input  logic [CH_W-1:0] canal,
  output logic [N_CH-1:0] pwm_out,
  output logic [N_CH-1:0] periodo_fin,
  output logic [VW-1:0]   valor_sel
);
  // prescaler wide enough to hold (2^FREQ_W)*BASE_DIV
  localparam int PW = $clog2((2 ** FREQ_W) * BASE_DIV + 1);
  // bit 0/1: two-flop synchroniser, bit 2: previous synchronised level for edge detection
  logic [2:0] up_r, dn_r;
  logic step_up, step_dn, inc, dec;
  logic [VW-1:0] v_ch [N_CH];
  // synchronise both buttons and remember the last synchronised level
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      up_r <= '0;
      dn_r <= '0;
    end else begin
      up_r <= {up_r[1:0], userOpcUp};
      dn_r <= {dn_r[1:0], userOpcDown};
    end
  assign step_up = up_r[1] & ~up_r[2];
  assign step_dn = dn_r[1] & ~dn_r[2];
  // simultaneous up and down steps cancel out
  assign inc = step_up & ~step_dn;
  assign dec = step_dn & ~step_up;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [FREQ_W-1:0] f_pend, f_act;
    logic [DUTY_W-1:0] d_pend, d_act, phase;
    logic [PW-1:0] presc, term;
    logic sel, tick, fin, pwm;
    assign sel  = canal == CH_W'(i);
    assign term = (PW'(f_act) + PW'(1)) * PW'(BASE_DIV) - PW'(1);
    assign tick = presc == term;
    assign fin  = tick & (&phase);
    assign periodo_fin[i] = fin;
    assign pwm_out[i] = pwm;
    assign v_ch[i] = opcion ? VW'(d_pend) : VW'(f_pend);
    // saturating edit of the pending value selected by canal/opcion
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        f_pend <= FREQ_W'(FREQ_RST);
        d_pend <= DUTY_W'(DUTY_RST);
      end else if (sel) begin
        f_pend <= opcion ? f_pend : (inc && !(&f_pend)) ? f_pend + FREQ_W'(1) : (dec && |f_pend) ? f_pend - FREQ_W'(1) : f_pend;
        d_pend <= !opcion ? d_pend : (inc && !(&d_pend)) ? d_pend + DUTY_W'(1) : (dec && |d_pend) ? d_pend - DUTY_W'(1) : d_pend;
      end
    // free-running prescaler and phase; active settings only change at the period boundary
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        f_act <= FREQ_W'(FREQ_RST);
        d_act <= DUTY_W'(DUTY_RST);
        presc <= '0;
        phase <= '0;
        pwm   <= 1'b0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        phase <= tick ? phase + DUTY_W'(1) : phase;
        f_act <= fin ? f_pend : f_act;
        d_act <= fin ? d_pend : d_act;
        pwm   <= phase < d_act;
      end
  end
  // show the pending field of the selected channel, zero for a non-existent channel
  always_comb
    valor_sel = ({1'b0, canal} < (CH_W + 1)'(N_CH)) ? v_ch[canal] : '0;
endmodule

// File: doc/pwm_multicanal.md
PWM_MULTICANAL -- requirements
Module: pwm_multicanal

Interface
REQ-001 Parameter N_CH, default 2: number of independent PWM channels.
REQ-002 Parameter FREQ_W, default 4: width of per-channel frequency index f.
REQ-003 Parameter DUTY_W, default 4: width of per-channel duty d; period is 2^DUTY_W ticks.
REQ-004 Parameter BASE_DIV, default 2: clk cycles per tick at f=0.
REQ-005 Parameters FREQ_RST, default 0, and DUTY_RST, default 8: reset values of f and d.
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 opcion  in  1  edit target: 0 = frequency, 1 = duty.
REQ-009 userOpcUp  in  1  raw push-button, increment request.
REQ-010 userOpcDown  in  1  raw push-button, decrement request.
REQ-011 canal  in  CH_W = max(1, clog2(N_CH))  channel being edited/displayed.
REQ-012 pwm_out  out  N_CH  PWM waveform per channel.
REQ-013 periodo_fin  out  N_CH  one-cycle pulse on last clk of each channel period.
REQ-014 valor_sel  out  max(FREQ_W, DUTY_W)  pending f or d (per opcion) of channel canal, zero-extended.

Function
REQ-015 Each button SHALL pass a 2-flop synchroniser plus edge register; one rising edge yields one single-cycle step.
REQ-016 A step SHALL update the pending register on the 3rd rising clk after the button rises.
REQ-017 Up and down steps in the same cycle SHALL cancel (no change).
REQ-018 A step SHALL apply to the channel and field selected by canal/opcion sampled in the step cycle.
REQ-019 canal >= N_CH: steps SHALL be ignored and valor_sel SHALL read 0.
REQ-020 Pending f and d SHALL saturate: up at all-ones holds, down at 0 holds; no wrap-around.
REQ-021 Each channel SHALL hold active f_act/d_act, loaded from pending only in the cycle periodo_fin is high (glitch-free update).
REQ-022 Prescaler SHALL count 0..(f_act+1)*BASE_DIV-1 and emit a tick on terminal count, then wrap to 0.
REQ-023 Phase counter SHALL advance 0..2^DUTY_W-1 on each tick and wrap to 0; periodo_fin high on the terminal-count cycle at phase all-ones.
REQ-024 pwm_out[i] SHALL be registered, high while phase < d_act; d_act=0 gives constant low.
REQ-025 Period SHALL equal 2^DUTY_W*(f_act+1)*BASE_DIV clk; high time d_act*(f_act+1)*BASE_DIV clk.
REQ-026 Channels SHALL run free and independently; editing one SHALL not disturb another's phase.
REQ-027 Internal arithmetic SHALL be wide enough for (2^FREQ_W)*BASE_DIV without overflow.

Reset
REQ-028 rst low SHALL immediately clear pwm_out, periodo_fin, synchronisers, prescalers, phases.
REQ-029 rst low SHALL set all pending and active f to FREQ_RST and d to DUTY_RST.
REQ-030 Reset mid-period SHALL abort the period; first period after release starts at phase 0 with reset settings.

Verification (defaults)
REQ-031 Release rst -> each pwm_out period 32 clk, high 16 clk; periodo_fin every 32 clk; valor_sel=8 (opcion=1).
REQ-032 opcion=1, canal=1, one up press mid-period -> valor_sel=9 three clk later; current period unchanged (16 high); next period 18 high of 32; channel 0 unaffected.
REQ-033 opcion=1, canal=0, ten down presses -> valor_sel saturates at 0; pwm_out[0] constant low from next period boundary.
REQ-034 opcion=0, canal=0, three up presses -> f=3; period 128 clk, high 64 clk; twenty more presses -> f holds 15, period 512 clk.
REQ-035 Up and down pressed in same clk -> no value change; canal=2 with N_CH=2 -> presses ignored, valor_sel=0.
REQ-036 Assert rst mid-period with modified settings -> outputs 0 same cycle; after release f=0, d=8, 32-clk period.
